// File: rtl/video_timing_if.sv
// Raster timing bundle between the timing sequencer and the encoder chain.
//   pal_mode        : requested standard (1 = PAL, 0 = NTSC), into the sequencer
//   newframe/newline/startburst : one-clock encoder strobes
//   even_line/even_field        : line and field parity
//   pal_mode_active : standard currently in use
//   sync_n          : composite sync (0 = sync level)
//   active_video    : inside the active-video window
//   h_count/v_count : current clock-in-line and line-in-field
// Modports: master = sequencer side, slave = consumer side.
interface video_timing_if;
    localparam int unsigned H_W = 12;
    localparam int unsigned V_W = 10;

    logic           pal_mode;
    logic           newframe;
    logic           newline;
    logic           startburst;
    logic           even_line;
    logic           even_field;
    logic           pal_mode_active;
    logic           sync_n;
    logic           active_video;
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;

    modport master (
        input  pal_mode,
        output newframe, newline, startburst, even_line, even_field,
               pal_mode_active, sync_n, active_video, h_count, v_count
    );

    modport slave (
        output pal_mode,
        input  newframe, newline, startburst, even_line, even_field,
               pal_mode_active, sync_n, active_video, h_count, v_count
    );
endinterface

// File: rtl/video_timing_sequencer.sv
// Master raster timing controller for the composite encoder chain.
// Runs the horizontal/vertical counters, decodes encoder strobes, composite
// sync and the active-video window. The PAL/NTSC request is latched only at
// a frame wrap so carrier phase and chroma filters never see a mid-frame
// change.
// Ports: clk, rst (synchronous, active-high), vt (video_timing_if.master).
// Optional build macro CONFIG_VIDEO_TIMING_INTERLACE_EN: alternating
// FIELD+1 / FIELD line fields with toggling even_field; without it every
// field has FIELD lines and even_field stays 1.
module video_timing_sequencer #(
    parameter int unsigned PAL_LINE_CLKS  = 3072,
    parameter int unsigned NTSC_LINE_CLKS = 3048,
    parameter int unsigned PAL_LINES      = 312,
    parameter int unsigned NTSC_LINES     = 262,
    parameter int unsigned HSYNC_CLKS     = 226,
    parameter int unsigned BURST_START    = 269,
    parameter int unsigned ACTIVE_START   = 512,
    parameter int unsigned ACTIVE_END     = 3008,
    parameter int unsigned VSYNC_LINES    = 3,
    parameter int unsigned BLANK_LINES    = 20
) (
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master vt
);
    localparam int unsigned H_W = 12;
    localparam int unsigned V_W = 10;
    localparam int unsigned MIN_LINE = (PAL_LINE_CLKS < NTSC_LINE_CLKS) ?
                                       PAL_LINE_CLKS : NTSC_LINE_CLKS;

    localparam logic [H_W-1:0] PAL_H_LAST   = H_W'(PAL_LINE_CLKS - 1);
    localparam logic [H_W-1:0] NTSC_H_LAST  = H_W'(NTSC_LINE_CLKS - 1);
    localparam logic [H_W-1:0] PAL_BROAD    = H_W'(PAL_LINE_CLKS - HSYNC_CLKS);
    localparam logic [H_W-1:0] NTSC_BROAD   = H_W'(NTSC_LINE_CLKS - HSYNC_CLKS);
    localparam logic [V_W-1:0] PAL_V_LAST   = V_W'(PAL_LINES - 1);
    localparam logic [V_W-1:0] NTSC_V_LAST  = V_W'(NTSC_LINES - 1);

    // Parameter sanity, caught at elaboration.
    if (!(BURST_START < ACTIVE_START && ACTIVE_START < ACTIVE_END &&
          ACTIVE_END <= MIN_LINE)) begin : g_bad_window
        $error("video_timing_sequencer: burst/active window out of order");
    end
    if (!(HSYNC_CLKS < BURST_START)) begin : g_bad_hsync
        $error("video_timing_sequencer: HSYNC_CLKS must be below BURST_START");
    end
    if (!(PAL_LINE_CLKS <= 4096 && NTSC_LINE_CLKS <= 4096 &&
          PAL_LINES < 1024 && NTSC_LINES < 1024)) begin : g_bad_width
        $error("video_timing_sequencer: counts exceed counter widths");
    end

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           m_q, m_d;     // latched standard
    logic           f_q, f_d;     // 1 = even field
    logic [H_W-1:0] h_last;
    logic [V_W-1:0] v_last;
    logic [H_W-1:0] broad_end_d;
    logic           frame_wrap;
    logic           sync_low_d;

    // Next counter/mode state and the sync window for the updated position.
    always_comb begin
        h_d        = h_q + H_W'(1);
        v_d        = v_q;
        m_d        = m_q;
        f_d        = f_q;
        frame_wrap = 1'b0;
        h_last     = m_q ? PAL_H_LAST : NTSC_H_LAST;
`ifdef CONFIG_VIDEO_TIMING_INTERLACE_EN
        // Even fields carry the extra half-frame line.
        v_last     = (m_q ? PAL_V_LAST : NTSC_V_LAST) + V_W'(f_q);
`else
        v_last     = m_q ? PAL_V_LAST : NTSC_V_LAST;
`endif
        if (h_q == h_last) begin
            h_d = '0;
            if (v_q == v_last) begin
                v_d        = '0;
                frame_wrap = 1'b1;
            end else begin
                v_d = v_q + V_W'(1);
            end
        end
`ifdef CONFIG_VIDEO_TIMING_INTERLACE_EN
        // Mode may only change where an odd field completes the frame.
        if (frame_wrap) begin
            f_d = ~f_q;
            if (!f_q) begin
                m_d = vt.pal_mode;
            end
        end
`else
        f_d = 1'b1;
        if (frame_wrap) begin
            m_d = vt.pal_mode;
        end
`endif
        broad_end_d = m_d ? PAL_BROAD : NTSC_BROAD;
        if (v_d < V_W'(VSYNC_LINES)) begin
            sync_low_d = (h_d < broad_end_d);
        end else begin
            sync_low_d = (h_d < H_W'(HSYNC_CLKS));
        end
    end

    // Counters plus registered output decode of the updated position.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q                <= vt.pal_mode;
            h_q                <= vt.pal_mode ? PAL_H_LAST : NTSC_H_LAST;
            v_q                <= vt.pal_mode ? PAL_V_LAST : NTSC_V_LAST;
`ifdef CONFIG_VIDEO_TIMING_INTERLACE_EN
            f_q                <= 1'b0;   // first wrap starts an even field
`else
            f_q                <= 1'b1;
`endif
            vt.newframe        <= 1'b0;
            vt.newline         <= 1'b0;
            vt.startburst      <= 1'b0;
            vt.even_line       <= 1'b0;
            vt.even_field      <= 1'b1;
            vt.pal_mode_active <= 1'b0;
            vt.sync_n          <= 1'b1;
            vt.active_video    <= 1'b0;
            vt.h_count         <= '0;
            vt.v_count         <= '0;
        end else begin
            h_q                <= h_d;
            v_q                <= v_d;
            m_q                <= m_d;
            f_q                <= f_d;
            vt.newframe        <= (h_d == '0) && (v_d == '0);
            vt.newline         <= (h_d == '0);
            vt.startburst      <= (h_d == H_W'(BURST_START)) &&
                                  (v_d >= V_W'(BLANK_LINES));
            vt.even_line       <= ~v_d[0];
            vt.even_field      <= f_d;
            vt.pal_mode_active <= m_d;
            vt.sync_n          <= ~sync_low_d;
            vt.active_video    <= (v_d >= V_W'(BLANK_LINES)) &&
                                  (h_d >= H_W'(ACTIVE_START)) &&
                                  (h_d <  H_W'(ACTIVE_END));
            vt.h_count         <= h_d;
            vt.v_count         <= v_d;
        end
    end
endmodule

// File: tb/tb_video_timing_sequencer.sv
// Directed bench: full-size instance for line-level timing, scaled instance
// (40/30 clock lines, 6/4 line fields) for frame, mode-switch and field checks.
module tb_video_timing_sequencer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    video_timing_if vif_a ();
    video_timing_if vif_b ();

    video_timing_sequencer u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vt  (vif_a)
    );

    video_timing_sequencer #(
        .PAL_LINE_CLKS  (40),
        .NTSC_LINE_CLKS (30),
        .PAL_LINES      (6),
        .NTSC_LINES     (4),
        .HSYNC_CLKS     (4),
        .BURST_START    (6),
        .ACTIVE_START   (10),
        .ACTIVE_END     (26),
        .VSYNC_LINES    (1),
        .BLANK_LINES    (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vt  (vif_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // From a newframe sample on instance B, run to the next newframe.
    task automatic field_b(output int nlines, output int nclk, output int lmin, output int lmax);
        int len;
        nlines = 0; nclk = 0; lmin = 99999; lmax = 0; len = 0;
        while (nclk < 2000) begin
            step();
            nclk++;
            len++;
            if (vif_b.newline) begin
                nlines++;
                if (len < lmin) lmin = len;
                if (len > lmax) lmax = len;
                len = 0;
            end
            if (vif_b.newframe) break;
        end
    endtask

    // From a newline sample on instance A, gather one line's statistics.
    task automatic line_a(output int lowcnt, output int lastlow, output int bursts,
                          output int burst_h, output int actcnt, output int act_first,
                          output int act_last, output int len);
        lowcnt = 0; lastlow = -1; bursts = 0; burst_h = -1;
        actcnt = 0; act_first = -1; act_last = -1; len = 0;
        do begin
            if (!vif_a.sync_n) begin
                lowcnt++;
                lastlow = int'(vif_a.h_count);
            end
            if (vif_a.startburst) begin
                bursts++;
                burst_h = int'(vif_a.h_count);
            end
            if (vif_a.active_video) begin
                actcnt++;
                if (act_first < 0) act_first = int'(vif_a.h_count);
                act_last = int'(vif_a.h_count);
            end
            step();
            len++;
        end while (!vif_a.newline && len < 5000);
    endtask

    task automatic wait_line_a(input int target);
        int n;
        n = 0;
        while (!(vif_a.newline && int'(vif_a.v_count) == target) && n < 80000) begin
            step();
            n++;
        end
        check("wait_line_a", 32'(vif_a.v_count), 32'(target));
    endtask

    int exp_lines [4];
    int exp_clks  [4];
    int exp_len   [4];
    int exp_ef    [4];
    int exp_pm    [4];

    initial begin
        int nl, nc, lmin, lmax;
        int lowcnt, lastlow, bursts, burst_h, actcnt, act_first, act_last, len;
        logic ef, pm;

`ifdef CONFIG_VIDEO_TIMING_INTERLACE_EN
        exp_lines = '{7, 6, 5, 4};
        exp_clks  = '{280, 240, 150, 120};
        exp_len   = '{40, 40, 30, 30};
        exp_ef    = '{1, 0, 1, 0};
        exp_pm    = '{1, 1, 0, 0};
`else
        exp_lines = '{6, 4, 4, 4};
        exp_clks  = '{240, 120, 120, 120};
        exp_len   = '{40, 30, 30, 30};
        exp_ef    = '{1, 1, 1, 1};
        exp_pm    = '{1, 0, 0, 0};
`endif

        rst_a = 1'b1;
        rst_b = 1'b1;
        vif_a.pal_mode = 1'b1;
        vif_b.pal_mode = 1'b1;
        repeat (3) step();

        // Reset state on the full-size instance
        check("rst_newframe",   32'(vif_a.newframe), 0);
        check("rst_newline",    32'(vif_a.newline), 0);
        check("rst_startburst", 32'(vif_a.startburst), 0);
        check("rst_even_line",  32'(vif_a.even_line), 0);
        check("rst_active",     32'(vif_a.active_video), 0);
        check("rst_sync_n",     32'(vif_a.sync_n), 1);
        check("rst_even_field", 32'(vif_a.even_field), 1);
        check("rst_h_count",    32'(vif_a.h_count), 0);
        check("rst_v_count",    32'(vif_a.v_count), 0);

        // Scaled instance: field lengths, mode latch at frame boundary
        rst_b = 1'b0;
        step();
        check("b_first_newframe", 32'(vif_b.newframe), 1);
        check("b_first_h",        32'(vif_b.h_count), 0);
        check("b_first_v",        32'(vif_b.v_count), 0);
        vif_b.pal_mode = 1'b0;   // request lands mid-frame
        for (int i = 0; i < 4; i++) begin
            ef = vif_b.even_field;
            pm = vif_b.pal_mode_active;
            field_b(nl, nc, lmin, lmax);
            check($sformatf("b_f%0d_lines", i),      32'(nl),   32'(exp_lines[i]));
            check($sformatf("b_f%0d_clks", i),       32'(nc),   32'(exp_clks[i]));
            check($sformatf("b_f%0d_line_min", i),   32'(lmin), 32'(exp_len[i]));
            check($sformatf("b_f%0d_line_max", i),   32'(lmax), 32'(exp_len[i]));
            check($sformatf("b_f%0d_even_field", i), 32'(ef),   32'(exp_ef[i]));
            check($sformatf("b_f%0d_pal_active", i), 32'(pm),   32'(exp_pm[i]));
        end

        // Full-size PAL: release and first line
        rst_a = 1'b0;
        step();
        check("a_newframe", 32'(vif_a.newframe), 1);
        check("a_newline",  32'(vif_a.newline), 1);
        check("a_h0",       32'(vif_a.h_count), 0);
        check("a_v0",       32'(vif_a.v_count), 0);
        check("a_pal",      32'(vif_a.pal_mode_active), 1);
        check("a_even_l0",  32'(vif_a.even_line), 1);

        line_a(lowcnt, lastlow, bursts, burst_h, actcnt, act_first, act_last, len);
        check("l0_len",      32'(len), 3072);
        check("l0_sync_low", 32'(lowcnt), 2846);
        check("l0_sync_end", 32'(lastlow), 2845);
        check("l0_bursts",   32'(bursts), 0);
        check("l0_active",   32'(actcnt), 0);
        check("l1_v",        32'(vif_a.v_count), 1);
        check("l1_even",     32'(vif_a.even_line), 0);
        check("l1_newframe", 32'(vif_a.newframe), 0);

        // Last blanked line and first burst line
        wait_line_a(19);
        line_a(lowcnt, lastlow, bursts, burst_h, actcnt, act_first, act_last, len);
        check("l19_len",      32'(len), 3072);
        check("l19_sync_low", 32'(lowcnt), 226);
        check("l19_bursts",   32'(bursts), 0);
        check("l19_active",   32'(actcnt), 0);
        check("l20_even",     32'(vif_a.even_line), 1);
        line_a(lowcnt, lastlow, bursts, burst_h, actcnt, act_first, act_last, len);
        check("l20_len",       32'(len), 3072);
        check("l20_sync_low",  32'(lowcnt), 226);
        check("l20_sync_end",  32'(lastlow), 225);
        check("l20_bursts",    32'(bursts), 1);
        check("l20_burst_h",   32'(burst_h), 269);
        check("l20_act_cnt",   32'(actcnt), 2496);
        check("l20_act_first", 32'(act_first), 512);
        check("l20_act_last",  32'(act_last), 3007);

        // Mid-line reset
        for (int n = 0; n < 4000 && int'(vif_a.h_count) != 1500; n++) step();
        check("mid_h",      32'(vif_a.h_count), 1500);
        check("mid_active", 32'(vif_a.active_video), 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("mr_newframe",   32'(vif_a.newframe), 0);
        check("mr_newline",    32'(vif_a.newline), 0);
        check("mr_startburst", 32'(vif_a.startburst), 0);
        check("mr_active",     32'(vif_a.active_video), 0);
        check("mr_sync_n",     32'(vif_a.sync_n), 1);
        check("mr_h",          32'(vif_a.h_count), 0);
        step();
        check("mr_post_newframe", 32'(vif_a.newframe), 1);
        check("mr_post_h",        32'(vif_a.h_count), 0);

        // Full-size NTSC line 0
        vif_a.pal_mode = 1'b0;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        step();
        check("ntsc_newframe", 32'(vif_a.newframe), 1);
        check("ntsc_pal",      32'(vif_a.pal_mode_active), 0);
        line_a(lowcnt, lastlow, bursts, burst_h, actcnt, act_first, act_last, len);
        check("ntsc_l0_len",      32'(len), 3048);
        check("ntsc_l0_sync_low", 32'(lowcnt), 2822);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
